// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   Decode/execute boundary directly upstream of the ALU. Holds a 32 x n
//   register file with write-through bypass and the ID/EX pipeline register
//   that drives the ALU operands and select one cycle after decode.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   stall, flush      : hold / bubble the pipeline register (flush wins)
//   in_valid          : decode presents a valid instruction
//   rs1_addr/rs2_addr : source register indices
//   imm, alu_src      : sign-extended immediate; 1 selects imm onto B
//   select_in         : ALU operation code
//   rd_addr_in        : destination index
//   reg_write_in      : instruction writes rd
//   wb_en/addr/data   : write-back port into the register file
//   A, B, select      : registered ALU operands and select
//   rd_addr           : registered destination index
//   reg_write         : registered write enable, qualified by valid
//   out_valid         : EX stage holds a valid instruction
module operand_fetch_stage #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [4:0]   rs1_addr,
  input  logic [4:0]   rs2_addr,
  input  logic [n-1:0] imm,
  input  logic         alu_src,
  input  logic [3:0]   select_in,
  input  logic [4:0]   rd_addr_in,
  input  logic         reg_write_in,
  input  logic         wb_en,
  input  logic [4:0]   wb_addr,
  input  logic [n-1:0] wb_data,
  output logic [n-1:0] A,
  output logic [n-1:0] B,
  output logic [3:0]   select,
  output logic [4:0]   rd_addr,
  output logic         reg_write,
  output logic         out_valid
);

  // ALU select that yields a zero result; used for reset and bubbles.
  localparam logic [3:0] SEL_BUBBLE = 4'b1111;

  logic [n-1:0] rf_q [32];

  logic [n-1:0] a_q, b_q;
  logic [3:0]   select_q;
  logic [4:0]   rd_q;
  logic         regw_q;
  logic         valid_q;
  logic [4:0]   rs1_q, rs2_q;
  logic         alu_src_q;

  logic         wb_commit;
  logic [n-1:0] rs1_val, rs2_val;
  logic [n-1:0] a_d, b_d;

  assign wb_commit = wb_en && (wb_addr != 5'd0);

  // Register file write port; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_commit) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Combinational reads with write-through bypass of the same-cycle write-back.
  always_comb begin
    rs1_val = rf_q[rs1_addr];
    if (rs1_addr == 5'd0) begin
      rs1_val = '0;
    end else if (wb_en && (wb_addr == rs1_addr)) begin
      rs1_val = wb_data;
    end
  end

  always_comb begin
    rs2_val = rf_q[rs2_addr];
    if (rs2_addr == 5'd0) begin
      rs2_val = '0;
    end else if (wb_en && (wb_addr == rs2_addr)) begin
      rs2_val = wb_data;
    end
  end

  // Operand next-state: capture from decode, or refresh held operands while
  // stalled so a write-back landing during the stall is not lost.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (stall) begin
      if (wb_commit && (wb_addr == rs1_q)) begin
        a_d = wb_data;
      end
      if (wb_commit && (wb_addr == rs2_q) && !alu_src_q) begin
        b_d = wb_data;
      end
    end else begin
      a_d = rs1_val;
      b_d = alu_src ? imm : rs2_val;
    end
  end

  // ID/EX register; priority rst > flush > stall > capture.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      a_q       <= '0;
      b_q       <= '0;
      select_q  <= SEL_BUBBLE;
      rd_q      <= '0;
      regw_q    <= 1'b0;
      valid_q   <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      alu_src_q <= 1'b0;
    end else if (stall) begin
      a_q <= a_d;
      b_q <= b_d;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      select_q  <= select_in;
      rd_q      <= rd_addr_in;
      regw_q    <= reg_write_in && in_valid;
      valid_q   <= in_valid;
      rs1_q     <= rs1_addr;
      rs2_q     <= rs2_addr;
      alu_src_q <= alu_src;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign select    = select_q;
  assign rd_addr   = rd_q;
  assign reg_write = regw_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed self-checking bench for operand_fetch_stage.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr_in, wb_addr;
  logic [31:0] imm, wb_data;
  logic        alu_src, reg_write_in, wb_en;
  logic [3:0]  select_in;
  logic [31:0] A, B;
  logic [3:0]  select;
  logic [4:0]  rd_addr;
  logic        reg_write, out_valid;

  int checks = 0;
  int errors = 0;

  operand_fetch_stage #(.n(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .in_valid     (in_valid),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .imm          (imm),
    .alu_src      (alu_src),
    .select_in    (select_in),
    .rd_addr_in   (rd_addr_in),
    .reg_write_in (reg_write_in),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .A            (A),
    .B            (B),
    .select       (select),
    .rd_addr      (rd_addr),
    .reg_write    (reg_write),
    .out_valid    (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0; in_valid = 0;
    rs1_addr = 0; rs2_addr = 0; rd_addr_in = 0; imm = 0;
    alu_src = 0; reg_write_in = 0; select_in = 4'b0000;
    wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic src,
                       input logic [31:0] im, input logic [3:0] sel, input logic [4:0] rd,
                       input logic rw);
    in_valid = 1; rs1_addr = r1; rs2_addr = r2; alu_src = src; imm = im;
    select_in = sel; rd_addr_in = rd; reg_write_in = rw;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_en = en; wb_addr = addr; wb_data = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    // Reset
    rst = 1;
    tick();
    rst = 0;
    check_eq("rst_A", A, 32'h0);
    check_eq("rst_B", B, 32'h0);
    check_eq("rst_sel", {28'h0, select}, 32'hF);
    check_eq("rst_rd", {27'h0, rd_addr}, 32'h0);
    check_eq("rst_rw", {31'h0, reg_write}, 32'h0);
    check_eq("rst_valid", {31'h0, out_valid}, 32'h0);

    // x0 write is discarded
    wb(1, 0, 32'hDEADBEEF);
    tick();
    wb(0, 0, 0);
    issue(0, 0, 0, 0, 4'b0010, 0, 0);
    tick();
    check_eq("x0_A", A, 32'h0);
    check_eq("x0_B", B, 32'h0);
    check_eq("x0_valid", {31'h0, out_valid}, 32'h1);

    // Basic capture
    idle();
    wb(1, 5, 32'd7);
    tick();
    wb(1, 6, 32'd3);
    tick();
    wb(0, 0, 0);
    issue(5, 6, 0, 0, 4'b0110, 7, 1);
    tick();
    check_eq("cap_A", A, 32'd7);
    check_eq("cap_B", B, 32'd3);
    check_eq("cap_sel", {28'h0, select}, 32'h6);
    check_eq("cap_valid", {31'h0, out_valid}, 32'h1);
    check_eq("cap_rd", {27'h0, rd_addr}, 32'd7);
    check_eq("cap_rw", {31'h0, reg_write}, 32'h1);

    // Bypass of same-cycle write-back
    wb(1, 5, 32'd100);
    tick();
    check_eq("byp_A", A, 32'd100);
    check_eq("byp_B", B, 32'd3);
    wb(0, 0, 0);
    tick();
    check_eq("byp_commit_A", A, 32'd100);

    // Immediate onto B
    issue(5, 6, 1, 32'hFFFFFFFC, 4'b0010, 8, 1);
    tick();
    check_eq("imm_B", B, 32'hFFFFFFFC);
    check_eq("imm_A", A, 32'd100);

    // Stall with refresh of A then B
    issue(5, 6, 0, 0, 4'b0000, 9, 1);
    tick();
    check_eq("pre_stall_A", A, 32'd100);
    stall = 1;
    issue(6, 5, 1, 32'h1234, 4'b0001, 2, 0);
    wb(1, 5, 32'd55);
    tick();
    check_eq("stall1_A", A, 32'd55);
    check_eq("stall1_B", B, 32'd3);
    check_eq("stall1_sel", {28'h0, select}, 32'h0);
    check_eq("stall1_valid", {31'h0, out_valid}, 32'h1);
    check_eq("stall1_rd", {27'h0, rd_addr}, 32'd9);
    wb(1, 6, 32'd66);
    tick();
    check_eq("stall2_A", A, 32'd55);
    check_eq("stall2_B", B, 32'd66);
    check_eq("stall2_sel", {28'h0, select}, 32'h0);
    check_eq("stall2_valid", {31'h0, out_valid}, 32'h1);

    // Held alu_src=1: B keeps imm during stall write-back to rs2
    stall = 0;
    wb(0, 0, 0);
    issue(5, 6, 1, 32'h10, 4'b0010, 4, 1);
    tick();
    stall = 1;
    wb(1, 6, 32'd77);
    tick();
    check_eq("stall_imm_B", B, 32'h10);
    stall = 0;
    wb(0, 0, 0);

    // in_valid=0 capture: operands load, valid/reg_write drop
    issue(6, 0, 0, 0, 4'b0001, 3, 1);
    in_valid = 0;
    tick();
    check_eq("inv_valid", {31'h0, out_valid}, 32'h0);
    check_eq("inv_rw", {31'h0, reg_write}, 32'h0);
    check_eq("inv_A", A, 32'd77);
    check_eq("inv_sel", {28'h0, select}, 32'h1);

    // Stall + flush: flush wins; flush write-back still commits
    issue(5, 6, 0, 0, 4'b0010, 1, 1);
    stall = 1; flush = 1;
    wb(1, 4, 32'd44);
    tick();
    check_eq("flush_valid", {31'h0, out_valid}, 32'h0);
    check_eq("flush_rw", {31'h0, reg_write}, 32'h0);
    check_eq("flush_sel", {28'h0, select}, 32'hF);
    check_eq("flush_A", A, 32'h0);
    stall = 0; flush = 0;
    wb(0, 0, 0);
    issue(4, 5, 0, 0, 4'b0010, 1, 1);
    tick();
    check_eq("flush_wb_A", A, 32'd44);
    check_eq("flush_keep_B", B, 32'd55);

    // Reset with concurrent write-back: dropped, registers cleared
    rst = 1;
    wb(1, 3, 32'd9);
    tick();
    rst = 0;
    wb(0, 0, 0);
    check_eq("rst2_valid", {31'h0, out_valid}, 32'h0);
    check_eq("rst2_sel", {28'h0, select}, 32'hF);
    issue(3, 5, 0, 0, 4'b0010, 1, 1);
    tick();
    check_eq("rst2_x3", A, 32'h0);
    check_eq("rst2_x5", B, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
